// File: rtl/mxv_nnbit_mkcc_seq_pkg.sv
// Shared types and sizing helpers for the matrix-vector sequencer.
package mxv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CLR, FEED, WAIT, OUT, DONE} state_t;

  function automatic int result_width(int n, int k);
    return 2 * (n - 1) + k;
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxv_nnbit_mkcc_seq_if.sv
// Load stream, MAC drive/return and result stream of the sequencer.
interface mxv_nnbit_mkcc_seq_if #(
  parameter int N = 8,
  parameter int L = 17
);
  logic                start;
  logic                ld_valid;
  logic                ld_ready;
  logic signed [N-1:0] ld_data;
  logic                mac_rst;
  logic signed [N-1:0] g_input;
  logic signed [N-1:0] e_input;
  logic signed [L-1:0] o;
  logic                res_valid;
  logic                res_ready;
  logic signed [L-1:0] res_data;
  logic                res_last;
  logic                done;

  modport master (
    input  start, ld_valid, ld_data, o, res_ready,
    output ld_ready, mac_rst, g_input, e_input, res_valid, res_data, res_last, done
  );

  modport slave (
    output start, ld_valid, ld_data, o, res_ready,
    input  ld_ready, mac_rst, g_input, e_input, res_valid, res_data, res_last, done
  );
endinterface

// File: rtl/mxv_nnbit_mkcc_seq_operand_store.sv
// Register file holding E[0..K-1] followed by row-major G; one write port, async read.
module mxv_operand_store
  import mxv_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 3,
  parameter int M = 3
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [idx_w(K + M * K)-1:0]   waddr,
  input  logic signed [N-1:0]           wdata,
  input  logic [idx_w(M)-1:0]           m,
  input  logic [idx_w(K)-1:0]           l,
  output logic signed [N-1:0]           g,
  output logic signed [N-1:0]           e
);
  localparam int D  = K + M * K;
  localparam int AW = idx_w(D);

  logic signed [N-1:0] mem [D];
  logic [AW-1:0]       g_addr;

  // G rows start right after the K vector entries.
  assign g_addr = AW'(K) + AW'(m) * AW'(K) + AW'(l);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign g = mem[g_addr];
  assign e = mem[AW'(l)];
endmodule

// File: rtl/mxv_nnbit_mkcc_seq.sv
// Sequences an external K-cycle MAC row by row to produce O = G*E over ready/valid streams.
module mxv_nnbit_mkcc_seq
  import mxv_pkg::*;
#(
  parameter int N       = 8,
  parameter int K       = 3,
  parameter int M       = 3,
  parameter int L       = result_width(N, K),
  parameter int MAC_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  mxv_nnbit_mkcc_seq_if.master bus
);
  localparam int LW = idx_w(K);
  localparam int MW = idx_w(M);
  localparam int IW = idx_w(K + M * K);
  localparam int WW = idx_w(MAC_LAT);

  state_t              state;
  logic [LW-1:0]       l;
  logic [MW-1:0]       m;
  logic [IW-1:0]       ld_idx;
  logic [WW-1:0]       w;
  logic [LW-1:0]       rd_l;
  logic signed [N-1:0] rd_g;
  logic signed [N-1:0] rd_e;
  logic                ld_fire;

  assign ld_fire = (state == LOAD) && bus.ld_valid && bus.ld_ready;

  // Read one element ahead so the registered MAC operands line up with l.
  assign rd_l = (state == FEED && l != LW'(K - 1)) ? l + LW'(1) : '0;

  mxv_operand_store #(.N(N), .K(K), .M(M)) u_store (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (ld_idx),
    .wdata (bus.ld_data),
    .m     (m),
    .l     (rd_l),
    .g     (rd_g),
    .e     (rd_e)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      bus.ld_ready  <= 1'b0;
      bus.mac_rst   <= 1'b1;
      bus.g_input   <= '0;
      bus.e_input   <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_last  <= 1'b0;
      bus.done      <= 1'b0;
      l             <= '0;
      m             <= '0;
      ld_idx        <= '0;
      w             <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state        <= LOAD;
          bus.ld_ready <= 1'b1;
          bus.mac_rst  <= 1'b0;
          ld_idx       <= '0;
        end
        LOAD: if (ld_fire) begin
          if (ld_idx == IW'(K + M * K - 1)) begin
            bus.ld_ready <= 1'b0;
            bus.mac_rst  <= 1'b1;
            m            <= '0;
            l            <= '0;
            state        <= CLR;
          end else begin
            ld_idx <= ld_idx + IW'(1);
          end
        end
        CLR: begin
          bus.mac_rst <= 1'b0;
          bus.g_input <= rd_g;
          bus.e_input <= rd_e;
          l           <= '0;
          state       <= FEED;
        end
        FEED: begin
          if (l == LW'(K - 1)) begin
            bus.g_input <= '0;
            bus.e_input <= '0;
            w           <= '0;
            state       <= WAIT;
          end else begin
            bus.g_input <= rd_g;
            bus.e_input <= rd_e;
            l           <= l + LW'(1);
          end
        end
        WAIT: begin
          if (w == WW'(MAC_LAT - 1)) begin
            bus.res_data  <= bus.o;
            bus.res_last  <= (m == MW'(M - 1));
            bus.res_valid <= 1'b1;
            state         <= OUT;
          end else begin
            w <= w + WW'(1);
          end
        end
        // Operands stay zero here, so a stalled consumer freezes the accumulator.
        OUT: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          bus.res_last  <= 1'b0;
          if (m == MW'(M - 1)) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            m           <= m + MW'(1);
            bus.mac_rst <= 1'b1;
            state       <= CLR;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mxv_nnbit_mkcc_seq.sv
// Bench for the sequencer with a behavioural MAC attached and a dot-product reference model.
module tb_mxv_nnbit_mkcc_seq;
  import mxv_pkg::*;

  localparam int N = 8;
  localparam int K = 3;
  localparam int M = 3;
  localparam int L = result_width(N, K);
  localparam int MAC_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   E [K];
  int   G [M][K];

  always #5 clk = ~clk;

  mxv_nnbit_mkcc_seq_if #(.N(N), .L(L)) bus ();

  mxv_nnbit_mkcc_seq #(.N(N), .K(K), .M(M), .L(L), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle-latency MAC: clears on mac_rst, otherwise accumulates g*e.
  always_ff @(posedge clk) begin
    if (bus.mac_rst) bus.o <= '0;
    else             bus.o <= bus.o + bus.g_input * bus.e_input;
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_golden();
    E = '{-38, -91, 47};
    G = '{'{29, 74, -39}, '{67, -71, 56}, '{75, -45, 34}};
  endtask

  task automatic set_random();
    for (int k = 0; k < K; k++) E[k] = int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < M; r++)
      for (int k = 0; k < K; k++) G[r][k] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < K; k++) E[k] = v;
    for (int r = 0; r < M; r++)
      for (int k = 0; k < K; k++) G[r][k] = v;
  endtask

  // ld_mode: 0 = valid always high, 1 = toggling, 2 = random
  task automatic do_load(input int ld_mode);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (idx < K + M * K && cyc < 1000) begin
      case (ld_mode)
        0:       bus.ld_valid = 1'b1;
        1:       bus.ld_valid = (cyc % 2 == 0);
        default: bus.ld_valid = 1'($urandom_range(0, 1));
      endcase
      bus.ld_data = (idx < K) ? N'(E[idx]) : N'(G[(idx - K) / K][(idx - K) % K]);
      acc = bus.ld_valid && bus.ld_ready;
      step();
      cyc++;
      if (acc) idx++;
    end
    bus.ld_valid = 1'b0;
    check("load_count", idx, K + M * K);
    check("ld_ready_drop", bus.ld_ready, 0);
  endtask

  // rr_mode: 0 = ready always, 1 = random, 2 = stall row 1 for five cycles
  task automatic do_results(input int rr_mode, input bit poke);
    int exp_o [M];
    int row, cyc, hold, mr_hi, mr_pulse;
    bit prev_mr, hs, fin;
    for (int r = 0; r < M; r++) begin
      exp_o[r] = 0;
      for (int k = 0; k < K; k++) exp_o[r] += G[r][k] * E[k];
    end
    row = 0; cyc = 0; hold = 0; mr_hi = 0; mr_pulse = 0; prev_mr = 1'b0; fin = 1'b0;
    while (!fin && cyc < 2000) begin
      if (bus.mac_rst) begin
        mr_hi++;
        if (!prev_mr) mr_pulse++;
      end
      prev_mr = bus.mac_rst;
      case (rr_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = !(row == 1 && hold < 5);
      endcase
      bus.start = poke && (bus.res_valid || bus.g_input != 0);
      if (bus.res_valid && !bus.res_ready) begin
        hold++;
        check("hold_data", bus.res_data, exp_o[row]);
        check("hold_g", bus.g_input, 0);
        check("hold_e", bus.e_input, 0);
      end
      hs = bus.res_valid && bus.res_ready;
      if (hs) begin
        check("res_data", bus.res_data, exp_o[row]);
        check("res_last", bus.res_last, (row == M - 1) ? 1 : 0);
        if (rr_mode == 2 && row == 1) check("stall_len", hold, 5);
      end
      step();
      cyc++;
      if (hs) begin
        hold = 0;
        if (row == M - 1) begin
          check("done_after_last", bus.done, 1);
          fin = 1'b1;
        end else begin
          row++;
        end
      end
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    check("run_finished", fin, 1);
    check("mac_rst_cycles", mr_hi, M);
    check("mac_rst_pulses", mr_pulse, M);
    step();
    check("done_one_cycle", bus.done, 0);
  endtask

  task automatic do_run(input int ld_mode, input int rr_mode, input bit poke);
    do_load(ld_mode);
    do_results(rr_mode, poke);
  endtask

  initial begin
    int cnt, cyc;
    bit prev;
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.res_ready = 1'b1;
    rst = 1'b0;
    step();
    step();
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_mac_rst", bus.mac_rst, 1);
    check("rst_g", bus.g_input, 0);
    check("rst_e", bus.e_input, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_last", bus.res_last, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b1;
    step();

    set_golden();
    do_run(0, 0, 1'b0);
    set_all(-128);
    do_run(0, 0, 1'b0);
    set_all(127);
    do_run(0, 0, 1'b0);
    set_golden();
    do_run(0, 2, 1'b0);
    do_run(1, 0, 1'b0);
    do_run(0, 0, 1'b1);

    // Reset while row 1 is being fed, then a full restart.
    do_load(0);
    cnt = 0; cyc = 0; prev = 1'b0;
    while (cyc < 200) begin
      if (bus.mac_rst && !prev) cnt++;
      if (cnt == 2 && !bus.mac_rst) break;
      prev = bus.mac_rst;
      step();
      cyc++;
    end
    check("reached_row1_feed", cnt, 2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_mac_rst", bus.mac_rst, 1);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_ld_ready", bus.ld_ready, 0);
    check("midrst_g", bus.g_input, 0);
    check("midrst_res_data", bus.res_data, 0);
    step();
    do_run(0, 0, 1'b0);

    set_random();
    for (int k = 0; k < K; k++) G[0][k] = 0;
    do_run(0, 0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      set_random();
      do_run(2, 1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
